sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
- Sequential controller for the other end of the magnitude-comparator interface. It drives the comparator's A operand with a guess and consumes the three relation flags (a_bigger, b_bigger, equals) returned for A = guess and B = an unknown target.
- It runs a binary search to find the target value in at most WIDTH+1 probes.
- It sits beside the existing combinational comparator on the board top level. Target is the B input (switches/test data); guess feeds A.
- It reports the found value, the probe count, and any error caused by inconsistent comparator flags.

Parameters:
- WIDTH, 4, operand width in bits; must match the comparator.
- CNT_W, 3, probe-counter width; must hold WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled in IDLE and DONE only.
- cmp_a_bigger  input  1  comparator flag: guess > target.
- cmp_b_bigger  input  1  comparator flag: target > guess.
- cmp_equals  input  1  comparator flag: guess == target.
- guess  output  WIDTH  registered value driven to comparator A input.
- busy  output  1  high while in PROBE.
- done  output  1  high while in DONE.
- found  output  1  valid when done: target located; guess holds it.
- err  output  1  valid when done: illegal flags or search exhausted.
- probes  output  CNT_W  number of probes evaluated in the last or current search.

Behaviour:
- Reset (async, rst_n low): state = IDLE. guess = 0, busy = 0, done = 0, found = 0, err = 0, probes = 0. Internal bounds lo = 0, hi = all-ones. Reset mid-search aborts immediately with no result retained.
- States: IDLE, PROBE, DONE. All outputs are registered.
- IDLE -> PROBE when start = 1:
  - lo = 0, hi = 2^WIDTH-1, guess = (lo+hi)>>1 computed with a WIDTH+1-bit sum (7 for WIDTH = 4).
  - probes = 0, found = 0, err = 0.
- PROBE, every cycle: the comparator is combinational, so the flags for the current registered guess are sampled at the next rising edge. probes increments by 1 per sampled cycle. Flags are decoded in this priority order:
  - Exactly one flag high is legal; any other combination (none, or two or more) -> DONE with err = 1, found = 0.
  - equals -> DONE, found = 1, guess is held.
  - a_bigger:
    - If guess == 0 -> DONE, err = 1 (underflow; target not representable).
    - Otherwise hi = guess-1 and guess = (lo + guess-1)>>1.
  - b_bigger:
    - If guess == all-ones -> DONE, err = 1 (overflow).
    - Otherwise lo = guess+1 and guess = (guess+1 + hi)>>1.
  - If the updated lo > hi -> DONE, err = 1 (inconsistent comparator history).
  - If probes would exceed WIDTH+1 without equals -> DONE, err = 1.
- DONE:
  - done = 1 and busy = 0. guess, found, err and probes are held.
  - start = 1 -> PROBE with a fresh search, initialised exactly as from IDLE.
  - Without start, remain in DONE.
- start is ignored in PROBE; a search cannot be restarted except via reset.
- Latency: from start accepted to done = probes + 1 cycles. Worst case for WIDTH = 4 is 5 probes, so done asserts 6 cycles after start.
- busy and done are never high together. found and err are never high together.

Test Plan:
- Target 11, start pulse -> guess sequence 7, 11. equals on the 2nd probe -> done = 1, found = 1, guess = 11, probes = 2, err = 0.
- Target 0 -> guess 7, 3, 1, 0 -> found = 1, guess = 0, probes = 4.
- Target 15 -> guess 7, 11, 13, 14, 15 -> found = 1, probes = 5; done high exactly 6 cycles after start.
- Flags forced all-zero on the first probe -> done = 1, err = 1, found = 0, probes = 1. Flags forced a_bigger and equals together -> same result.
- rst_n pulsed low during PROBE (after guess = 11) -> outputs immediately 0, state IDLE. A start after release performs a full new search from guess = 7.
- In DONE with target changed to 5, start pulse -> new search 7, 3, 5 -> found = 1, probes = 3. A start pulse asserted mid-PROBE has no effect.

Source files
------------

// File: rtl/sar_search_ctrl.sv
// Binary-search controller that drives comparator operand A and narrows [lo,hi] from the returned flags.
// One probe per cycle; done follows the accepted start by probes+1 cycles; start is only honoured in IDLE/DONE.
module sar_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_a_bigger,
  input  logic             cmp_b_bigger,
  input  logic             cmp_equals,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [CNT_W-1:0] probes
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d, lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] lo_n, hi_n;
  logic [CNT_W-1:0] probes_q, probes_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             found_q, found_d, err_q, err_d;
  logic             legal, step_ok;

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [CNT_W-1:0] MAX_PROBE = CNT_W'(WIDTH + 1);

  // Midpoint with a carry bit so lo+hi cannot wrap.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
    logic [WIDTH:0] s;
    s = {1'b0, l} + {1'b0, h};
    return s[WIDTH:1];
  endfunction

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probes_d = probes_q;
    busy_d   = busy_q;
    done_d   = done_q;
    found_d  = found_q;
    err_d    = err_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    step_ok  = 1'b0;
    legal    = ({cmp_a_bigger, cmp_b_bigger, cmp_equals} == 3'b100) ||
               ({cmp_a_bigger, cmp_b_bigger, cmp_equals} == 3'b010) ||
               ({cmp_a_bigger, cmp_b_bigger, cmp_equals} == 3'b001);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = PROBE;
          lo_d     = '0;
          hi_d     = ALL_ONES;
          guess_d  = mid('0, ALL_ONES);
          probes_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      PROBE: begin
        probes_d = probes_q + CNT_W'(1);
        if (!legal) begin
          err_d = 1'b1;
        end else if (cmp_equals) begin
          found_d = 1'b1;
        end else if (cmp_a_bigger) begin
          if (guess_q == '0) err_d = 1'b1;
          else begin
            hi_n    = guess_q - WIDTH'(1);
            step_ok = 1'b1;
          end
        end else begin
          if (guess_q == ALL_ONES) err_d = 1'b1;
          else begin
            lo_n    = guess_q + WIDTH'(1);
            step_ok = 1'b1;
          end
        end
        // A narrowing step can still fail on a crossed window or an exhausted probe budget.
        if (step_ok) begin
          if (lo_n > hi_n || probes_d >= MAX_PROBE) begin
            err_d = 1'b1;
          end else begin
            lo_d    = lo_n;
            hi_d    = hi_n;
            guess_d = mid(lo_n, hi_n);
          end
        end
        if (err_d || found_d) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '1;
      probes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probes_q <= probes_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: directed and random targets against an integer binary-search model.
module tb_sar_search_ctrl;

  logic       clk, rst_n, start;
  logic       cmp_a_bigger, cmp_b_bigger, cmp_equals;
  logic [3:0] guess, target;
  logic       busy, done, found, err;
  logic [2:0] probes;
  int         flag_mode;
  int         checks, errors;

  sar_search_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_a_bigger(cmp_a_bigger), .cmp_b_bigger(cmp_b_bigger), .cmp_equals(cmp_equals),
    .guess(guess), .busy(busy), .done(done), .found(found), .err(err), .probes(probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator, with forced flag patterns for the error cases.
  always_comb begin
    cmp_a_bigger = guess > target;
    cmp_b_bigger = target > guess;
    cmp_equals   = guess == target;
    if (flag_mode == 1) begin
      cmp_a_bigger = 1'b0; cmp_b_bigger = 1'b0; cmp_equals = 1'b0;
    end else if (flag_mode == 2) begin
      cmp_a_bigger = 1'b1; cmp_b_bigger = 1'b0; cmp_equals = 1'b1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one search from IDLE/DONE and checks the probe trail and result.
  task automatic run_search(input int tgt, input int mode, input bit poke);
    int exp_q[$];
    int lo, hi, g, cyc, idx;
    bit exp_found;
    target    = 4'(tgt);
    flag_mode = mode;
    if (mode == 0) begin
      lo = 0; hi = 15;
      while (1) begin
        g = (lo + hi) / 2;
        exp_q.push_back(g);
        if (g == tgt) break;
        if (g > tgt) hi = g - 1; else lo = g + 1;
      end
      exp_found = 1'b1;
    end else begin
      exp_q.push_back(7);
      exp_found = 1'b0;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; idx = 0;
    while (!done && cyc < 20) begin
      check("busy", int'(busy), 1);
      check("probes_run", int'(probes), idx);
      if (idx < exp_q.size()) check("guess_seq", int'(guess), exp_q[idx]);
      idx++;
      if (poke) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("done", int'(done), 1);
    check("busy_off", int'(busy), 0);
    check("latency", cyc, exp_q.size() + 1);
    check("found", int'(found), int'(exp_found));
    check("err", int'(err), int'(!exp_found));
    check("probes", int'(probes), exp_q.size());
    if (exp_found) check("guess_final", int'(guess), tgt);
    flag_mode = 0;
    @(negedge clk);
    check("done_hold", int'(done), 1);
    check("probes_hold", int'(probes), exp_q.size());
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; target = 4'd0; flag_mode = 0;
    #1;
    check("rst_guess", int'(guess), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_err", int'(err), 0);
    check("rst_probes", int'(probes), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    run_search(11, 0, 1'b0);
    run_search(0, 0, 1'b0);
    run_search(15, 0, 1'b0);
    run_search(3, 1, 1'b0);
    run_search(3, 2, 1'b0);
    run_search(5, 0, 1'b1);

    // Abort after the second probe guess appears.
    target = 4'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_guess", int'(guess), 11);
    rst_n = 1'b0;
    #1;
    check("abort_guess", int'(guess), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_probes", int'(probes), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", int'(busy), 0);
    run_search(11, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_search(int'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
